sn76489_bus_writer: RTL and testbench

Host-side register write decoder for the SN76489 PSG core. It accepts the chip's byte-wide write protocol (latch/data bytes qualified by an active-low write strobe) and keeps the programmable register file: three tone periods, four attenuations and the noise control. It drives the `control`, `tone_freq` and `restart_noise` inputs of the noise generator and the compare inputs of the tone generators. It also generates the READY wait-state handshake back to the host.

---
 rtl/sn76489_pkg.sv | 32 +++
 rtl/sn76489_bus_writer_ready_timer.sv | 26 ++
 rtl/sn76489_bus_writer.sv | 100 ++++++++++
 tb/tb_sn76489_bus_writer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sn76489_pkg.sv
// Shared constants, target-register enum and write helpers for the SN76489 host bus writer.
package sn76489_pkg;

  localparam int LATCH_BIT = 7;
  localparam int CHAN_HI   = 6;
  localparam int CHAN_LO   = 5;
  localparam int TYPE_BIT  = 4;
  localparam int TONE_BITS = 10;

  localparam logic [1:0] NOISE_CHAN = 2'd3;
  localparam logic [3:0] VOLUME_OFF = 4'hF;

  typedef enum logic [1:0] {
    TGT_TONE  = 2'd0,
    TGT_VOL   = 2'd1,
    TGT_NOISE = 2'd2
  } target_e;

  function automatic target_e target_of(input logic [1:0] chan, input logic is_vol);
    if (is_vol)                 return TGT_VOL;
    else if (chan == NOISE_CHAN) return TGT_NOISE;
    else                         return TGT_TONE;
  endfunction

  // Latch bytes replace the low nibble, data bytes the upper six bits.
  function automatic logic [TONE_BITS-1:0] tone_write(input logic [TONE_BITS-1:0] cur,
                                                      input logic [7:0] d);
    if (d[LATCH_BIT]) return {cur[TONE_BITS-1:4], d[3:0]};
    else              return {d[5:0], cur[3:0]};
  endfunction

endpackage

// File: rtl/sn76489_bus_writer_ready_timer.sv
// READY wait-state timer: loads READY_CYCLES on start and counts down to zero; ready while at zero.
module ready_timer #(
  parameter int READY_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic ready
);

  localparam int CW = $clog2(READY_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (start)
      count <= CW'(READY_CYCLES);
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign ready = (count == '0);

endmodule

// File: rtl/sn76489_bus_writer.sv
// SN76489 host write decoder: latch/data byte protocol, register file and READY handshake.
// Define SN_READY_WAIT_EN to build the READY wait-state counter; otherwise ready is tied high.
module sn76489_bus_writer
  import sn76489_pkg::*;
#(
  parameter int COUNTER_BITS = 10,
  parameter int READY_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              data,
  input  logic                    we_n,
  output logic                    ready,
  output logic [COUNTER_BITS-1:0] tone_freq0,
  output logic [COUNTER_BITS-1:0] tone_freq1,
  output logic [COUNTER_BITS-1:0] tone_freq2,
  output logic [3:0]              volume0,
  output logic [3:0]              volume1,
  output logic [3:0]              volume2,
  output logic [3:0]              volume3,
  output logic [2:0]              noise_control,
  output logic                    restart_noise
);

  if (COUNTER_BITS != TONE_BITS) begin : g_bad_counter_bits
    $error("sn76489_bus_writer: COUNTER_BITS must be 10");
  end

  logic       we_n_q;
  logic [1:0] chan_q;
  logic       is_vol_q;
  logic       accept;
  logic [1:0] chan_w;
  logic       is_vol_w;
  target_e    tgt;

  // A latch byte retargets the write in the same cycle it arrives.
  always_comb begin
    chan_w   = data[LATCH_BIT] ? data[CHAN_HI:CHAN_LO] : chan_q;
    is_vol_w = data[LATCH_BIT] ? data[TYPE_BIT]        : is_vol_q;
    tgt      = target_of(chan_w, is_vol_w);
  end

  assign accept = ~we_n & we_n_q & ready;

`ifdef SN_READY_WAIT_EN
  ready_timer #(.READY_CYCLES(READY_CYCLES)) u_ready_timer (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .ready (ready)
  );
`else
  assign ready = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      we_n_q        <= 1'b1;
      chan_q        <= 2'd0;
      is_vol_q      <= 1'b0;
      tone_freq0    <= '0;
      tone_freq1    <= '0;
      tone_freq2    <= '0;
      volume0       <= VOLUME_OFF;
      volume1       <= VOLUME_OFF;
      volume2       <= VOLUME_OFF;
      volume3       <= VOLUME_OFF;
      noise_control <= 3'd0;
      restart_noise <= 1'b0;
    end else begin
      we_n_q        <= we_n;
      restart_noise <= accept && (tgt == TGT_NOISE);
      if (accept) begin
        chan_q   <= chan_w;
        is_vol_q <= is_vol_w;
        case (tgt)
          TGT_TONE: begin
            case (chan_w)
              2'd0:    tone_freq0 <= tone_write(tone_freq0, data);
              2'd1:    tone_freq1 <= tone_write(tone_freq1, data);
              default: tone_freq2 <= tone_write(tone_freq2, data);
            endcase
          end
          TGT_VOL: begin
            case (chan_w)
              2'd0:    volume0 <= data[3:0];
              2'd1:    volume1 <= data[3:0];
              2'd2:    volume2 <= data[3:0];
              default: volume3 <= data[3:0];
            endcase
          end
          TGT_NOISE: noise_control <= data[2:0];
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sn76489_bus_writer.sv
// Scoreboard bench for sn76489_bus_writer: expected register snapshots queued per write, checked at N+1.
module tb_sn76489_bus_writer;

`ifdef SN_READY_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  localparam int RC = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = 8'h00;
  logic       we_n = 1'b1;
  logic       ready;
  logic [9:0] tone_freq0, tone_freq1, tone_freq2;
  logic [3:0] volume0, volume1, volume2, volume3;
  logic [2:0] noise_control;
  logic       restart_noise;

  sn76489_bus_writer #(.COUNTER_BITS(10), .READY_CYCLES(RC)) dut (
    .clk           (clk),
    .reset         (reset),
    .data          (data),
    .we_n          (we_n),
    .ready         (ready),
    .tone_freq0    (tone_freq0),
    .tone_freq1    (tone_freq1),
    .tone_freq2    (tone_freq2),
    .volume0       (volume0),
    .volume1       (volume1),
    .volume2       (volume2),
    .volume3       (volume3),
    .noise_control (noise_control),
    .restart_noise (restart_noise)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [9:0] t0, t1, t2;
    logic [3:0] v0, v1, v2, v3;
    logic [2:0] nc;
    logic       rn;
  } snap_t;

  snap_t      sb[$];
  logic [9:0] m_tone[3];
  logic [3:0] m_vol[4];
  logic [2:0] m_nc;
  logic [1:0] m_chan;
  logic       m_isvol;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         acc_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_tone[i] = 10'd0;
    for (int i = 0; i < 4; i++) m_vol[i] = 4'hF;
    m_nc = 3'd0; m_chan = 2'd0; m_isvol = 1'b0;
  endtask

  // Applies one accepted byte to the model; returns 1 if it targeted the noise register.
  function automatic bit model_apply(input logic [7:0] d);
    if (d[7]) begin
      m_chan  = d[6:5];
      m_isvol = d[4];
    end
    if (m_isvol) begin
      m_vol[m_chan] = d[3:0];
      return 1'b0;
    end
    if (m_chan == 2'd3) begin
      m_nc = d[2:0];
      return 1'b1;
    end
    if (d[7]) m_tone[m_chan][3:0] = d[3:0];
    else      m_tone[m_chan][9:4] = d[5:0];
    return 1'b0;
  endfunction

  function automatic snap_t model_snap(input logic rn);
    snap_t s;
    s.t0 = m_tone[0]; s.t1 = m_tone[1]; s.t2 = m_tone[2];
    s.v0 = m_vol[0];  s.v1 = m_vol[1];  s.v2 = m_vol[2]; s.v3 = m_vol[3];
    s.nc = m_nc;      s.rn = rn;
    return s;
  endfunction

  task automatic compare_snap(input string tag);
    snap_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_tone0"}, 32'(tone_freq0), 32'(e.t0));
    check({tag, "_tone1"}, 32'(tone_freq1), 32'(e.t1));
    check({tag, "_tone2"}, 32'(tone_freq2), 32'(e.t2));
    check({tag, "_vol0"}, 32'(volume0), 32'(e.v0));
    check({tag, "_vol1"}, 32'(volume1), 32'(e.v1));
    check({tag, "_vol2"}, 32'(volume2), 32'(e.v2));
    check({tag, "_vol3"}, 32'(volume3), 32'(e.v3));
    check({tag, "_noise"}, 32'(noise_control), 32'(e.nc));
    check({tag, "_restart"}, 32'(restart_noise), 32'(e.rn));
  endtask

  task automatic write_byte(input string tag, input logic [7:0] d, input bit in_wait);
    bit acc, rn;
    acc = !(WAIT_EN && in_wait);
    rn  = 1'b0;
    @(negedge clk);
    data = d;
    we_n = 1'b0;
    if (acc) rn = model_apply(d);
    sb.push_back(model_snap(rn));
    @(posedge clk); #1;
    we_n = 1'b1;
    if (acc) acc_cyc = cyc;
    compare_snap(tag);
    check({tag, "_ready"}, 32'(ready), 32'(!WAIT_EN));
    @(posedge clk); #1;
    check({tag, "_restart_end"}, 32'(restart_noise), 32'd0);
  endtask

  task automatic wait_ready(input string tag);
    int g = 0;
    while (ready !== 1'b1 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check({tag, "_ready_rise"}, 32'(cyc - acc_cyc), WAIT_EN ? 32'(RC) : 32'd1);
  endtask

  initial begin
    int pulses;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    sb.push_back(model_snap(1'b0));
    compare_snap("reset");
    check("reset_ready", 32'(ready), 32'd1);

    write_byte("tone0_latch", 8'h8E, 1'b0); wait_ready("tone0_latch");
    write_byte("tone0_data", 8'h0F, 1'b0);  wait_ready("tone0_data");
    check("tone0_value", 32'(tone_freq0), 32'h0FE);

    write_byte("noise_latch", 8'hE5, 1'b0); wait_ready("noise_latch");
    write_byte("noise_data", 8'h03, 1'b0);  wait_ready("noise_data");

    write_byte("vol2_latch", 8'hD7, 1'b0);  wait_ready("vol2_latch");
    write_byte("vol2_data", 8'h0A, 1'b0);   wait_ready("vol2_data");

    // Dropped strobe inside the wait must neither write nor relatch.
    write_byte("vol1_latch", 8'hB3, 1'b0);
    repeat (4) @(posedge clk);
    write_byte("drop_9f", 8'h9F, 1'b1);
    wait_ready("drop_9f");
    write_byte("after_drop", 8'h05, 1'b0);  wait_ready("after_drop");

    // Strobe held low across the whole wait counts once.
    @(negedge clk);
    data = 8'hE1; we_n = 1'b0;
    sb.push_back(model_snap(model_apply(8'hE1)));
    @(posedge clk); #1;
    compare_snap("held_low");
    pulses = 0;
    for (int i = 0; i < RC + 8; i++) begin
      @(posedge clk); #1;
      if (restart_noise === 1'b1) pulses++;
    end
    check("held_low_pulses", 32'(pulses), 32'd0);
    check("held_low_ready", 32'(ready), 32'd1);
    @(negedge clk); we_n = 1'b1;
    @(posedge clk); #1;

    // Reset part-way into a wait.
    write_byte("vol0_latch", 8'h91, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    sb.push_back(model_snap(1'b0));
    compare_snap("mid_wait_reset");
    check("mid_wait_reset_ready", 32'(ready), 32'd1);

    // Reset and strobe together: the write is lost.
    @(negedge clk); data = 8'h90; we_n = 1'b0;
    @(posedge clk); #1;
    check("reset_vs_strobe_vol0", 32'(volume0), 32'hF);
    @(negedge clk); we_n = 1'b1;
    @(negedge clk); reset = 1'b0;

    // Latch was cleared to tone 0, so a bare data byte lands in tone0[9:4].
    write_byte("post_reset_data", 8'h05, 1'b0); wait_ready("post_reset_data");
    check("post_reset_tone0", 32'(tone_freq0), 32'h050);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
